mem_arbiter: RTL

Shares the single read/write RAM port (port B: mem_wr / mem_addr / mem_src / mem_data) between the instruction fetch unit and the load/store unit. It accepts one request at a time, sequences the RAM's 1-cycle read latency, and returns data with a one-cycle done pulse. It sits between the i_fetch/LSU request interfaces and the cpu top-level memory pins.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arbiter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for mem_arbiter: FSM state encoding and requester IDs.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single RAM port between instruction fetch and load/store, one request at a time.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise load/store has fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  if_valid,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic                  if_flush,
  output logic                  if_done,
  output logic [DATA_WIDTH-1:0] if_data,
  input  logic                  ls_valid,
  input  logic                  ls_wr,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_done,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_src,
  input  logic [DATA_WIDTH-1:0] mem_data
);

  arb_state_t            state, state_nxt;
  logic                  owner, owner_nxt;
  logic                  cancel, cancel_nxt;
  logic                  mem_wr_nxt;
  logic [ADDR_WIDTH-1:0] mem_addr_nxt;
  logic [DATA_WIDTH-1:0] mem_src_nxt;
  logic                  if_done_nxt, ls_done_nxt;
  logic [DATA_WIDTH-1:0] if_data_nxt, ls_rdata_nxt;
  logic                  if_elig, ls_elig, grant_ls;

  // A requester whose done pulse is high this cycle has already been served.
  assign if_elig = if_valid & ~if_done;
  assign ls_elig = ls_valid & ~ls_done;

`ifdef MEM_ARB_RR_EN
  logic last_grant, last_grant_nxt;

  assign grant_ls = ls_elig & (~if_elig | (last_grant == REQ_IF));
`else
  assign grant_ls = ls_elig;
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      owner    <= REQ_IF;
      cancel   <= 1'b0;
      mem_wr   <= 1'b0;
      mem_addr <= '0;
      mem_src  <= '0;
      if_done  <= 1'b0;
      ls_done  <= 1'b0;
      if_data  <= '0;
      ls_rdata <= '0;
`ifdef MEM_ARB_RR_EN
      last_grant <= REQ_IF;
`endif
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      cancel   <= cancel_nxt;
      mem_wr   <= mem_wr_nxt;
      mem_addr <= mem_addr_nxt;
      mem_src  <= mem_src_nxt;
      if_done  <= if_done_nxt;
      ls_done  <= ls_done_nxt;
      if_data  <= if_data_nxt;
      ls_rdata <= ls_rdata_nxt;
`ifdef MEM_ARB_RR_EN
      last_grant <= last_grant_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    owner_nxt    = owner;
    cancel_nxt   = cancel;
    mem_wr_nxt   = mem_wr;
    mem_addr_nxt = mem_addr;
    mem_src_nxt  = mem_src;
    if_done_nxt  = 1'b0;
    ls_done_nxt  = 1'b0;
    if_data_nxt  = if_data;
    ls_rdata_nxt = ls_rdata;
`ifdef MEM_ARB_RR_EN
    last_grant_nxt = last_grant;
`endif

    case (state)
      IDLE: begin
        cancel_nxt = 1'b0;
        if (if_elig || ls_elig) begin
          state_nxt = ISSUE;
          if (grant_ls) begin
            owner_nxt    = REQ_LS;
            mem_addr_nxt = ls_addr;
            mem_src_nxt  = ls_wdata;
            mem_wr_nxt   = ls_wr;
          end else begin
            owner_nxt    = REQ_IF;
            mem_addr_nxt = if_addr;
            mem_wr_nxt   = 1'b0;
          end
`ifdef MEM_ARB_RR_EN
          last_grant_nxt = grant_ls ? REQ_LS : REQ_IF;
`endif
        end
      end

      // mem_wr being high here means the granted request is a store.
      ISSUE: begin
        if (mem_wr) begin
          mem_wr_nxt  = 1'b0;
          ls_done_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          state_nxt = WAIT;
          if ((owner == REQ_IF) && if_flush) begin
            cancel_nxt = 1'b1;
          end
        end
      end

      // A flush seen in ISSUE or here lets the RAM read finish but discards the word.
      WAIT: begin
        state_nxt  = IDLE;
        cancel_nxt = 1'b0;
        if (owner == REQ_LS) begin
          ls_rdata_nxt = mem_data;
          ls_done_nxt  = 1'b1;
        end else if (!(cancel || if_flush)) begin
          if_data_nxt = mem_data;
          if_done_nxt = 1'b1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
